// File: rtl/cpu_control_unit_pkg.sv
`default_nettype none
// cpu_control_unit_pkg: shared ISA constants, FSM states and CTRL word layout.
// Rev 1.0

package cpu_control_unit_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_MULI  = 6'h1d;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_JMP   = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_PUSH  = 6'h1b;
   localparam logic [5:0] OP_POP   = 6'h1c;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_MUL = 6'h2c;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2a;
   localparam logic [5:0] FN_SLL = 6'h01;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;

   localparam logic [5:0] ALU_NOP = 6'd0;
   localparam logic [5:0] ALU_ADD = 6'd1;
   localparam logic [5:0] ALU_SUB = 6'd2;
   localparam logic [5:0] ALU_MUL = 6'd3;
   localparam logic [5:0] ALU_SHR = 6'd4;
   localparam logic [5:0] ALU_SHL = 6'd5;
   localparam logic [5:0] ALU_AND = 6'd6;
   localparam logic [5:0] ALU_OR  = 6'd7;
   localparam logic [5:0] ALU_NOR = 6'd8;
   localparam logic [5:0] ALU_SLT = 6'd9;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_DECODE    = 3'd2;
   localparam logic [2:0] S_EXECUTE   = 3'd3;
   localparam logic [2:0] S_MEMORY    = 3'd4;
   localparam logic [2:0] S_WRITEBACK = 3'd5;
   localparam logic [2:0] S_HLT       = 3'd6;

   // Mux polarities: pc_sel_1 1=PC+1/0=R1, pc_sel_2 1=branch, pc_sel_3 0=jump;
   // wa_sel_3 1=r0/r31 path; wd_sel_3 1=PC+1; op2_sel_4 0=R2; ma_sel_2 1=PC.
   localparam int C_PC_LOAD   = 0;
   localparam int C_PC_SEL_1  = 1;
   localparam int C_PC_SEL_2  = 2;
   localparam int C_PC_SEL_3  = 3;
   localparam int C_IR_LOAD   = 4;
   localparam int C_R1_SEL    = 5;
   localparam int C_REG_R     = 6;
   localparam int C_REG_W     = 7;
   localparam int C_WA_SEL_1  = 8;
   localparam int C_WA_SEL_2  = 9;
   localparam int C_WA_SEL_3  = 10;
   localparam int C_WD_SEL_1  = 11;
   localparam int C_WD_SEL_2  = 12;
   localparam int C_WD_SEL_3  = 13;
   localparam int C_SP_LOAD   = 14;
   localparam int C_OP1_SEL   = 15;
   localparam int C_OP2_SEL_1 = 16;
   localparam int C_OP2_SEL_2 = 17;
   localparam int C_OP2_SEL_3 = 18;
   localparam int C_OP2_SEL_4 = 19;
   localparam int C_ALU_LSB   = 20;
   localparam int C_ALU_MSB   = 25;
   localparam int C_MA_SEL_1  = 26;
   localparam int C_MA_SEL_2  = 27;
   localparam int C_MD_SEL    = 28;

   typedef enum logic [3:0] {
      CL_RALU, CL_SHIFT, CL_JR, CL_IMM_S, CL_IMM_Z, CL_LUI, CL_BEQ,
      CL_BNE, CL_LW, CL_SW, CL_JMP, CL_JAL, CL_PUSH, CL_POP
   } instr_class_t;

   typedef struct packed {
      instr_class_t cls;
      logic [5:0]   alu_oprn;
      logic         illegal;
   } decode_t;

   function automatic logic is_mem_class(input instr_class_t c);
      return (c == CL_LW) || (c == CL_SW) || (c == CL_PUSH) || (c == CL_POP);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_control_unit_instr_decoder.sv
`default_nettype none
// cpu_control_unit_instr_decoder: opcode/funct to class, ALU operation and illegal flag.
// Rev 1.0

module cpu_control_unit_instr_decoder
   import cpu_control_unit_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output decode_t    o_dec
);

   decode_t w_dec;

   always_comb begin
      w_dec = '{cls: CL_RALU, alu_oprn: ALU_NOP, illegal: 1'b0};
      case (i_opcode)
         OP_RTYPE: begin
            case (i_funct)
               FN_ADD:  w_dec.alu_oprn = ALU_ADD;
               FN_SUB:  w_dec.alu_oprn = ALU_SUB;
               FN_MUL:  w_dec.alu_oprn = ALU_MUL;
               FN_AND:  w_dec.alu_oprn = ALU_AND;
               FN_OR:   w_dec.alu_oprn = ALU_OR;
               FN_NOR:  w_dec.alu_oprn = ALU_NOR;
               FN_SLT:  w_dec.alu_oprn = ALU_SLT;
               FN_SLL:  begin w_dec.cls = CL_SHIFT; w_dec.alu_oprn = ALU_SHL; end
               FN_SRL:  begin w_dec.cls = CL_SHIFT; w_dec.alu_oprn = ALU_SHR; end
               FN_JR:   w_dec.cls = CL_JR;
               default: w_dec.illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin w_dec.cls = CL_IMM_S; w_dec.alu_oprn = ALU_ADD; end
         OP_MULI: begin w_dec.cls = CL_IMM_S; w_dec.alu_oprn = ALU_MUL; end
         OP_SLTI: begin w_dec.cls = CL_IMM_S; w_dec.alu_oprn = ALU_SLT; end
         OP_ANDI: begin w_dec.cls = CL_IMM_Z; w_dec.alu_oprn = ALU_AND; end
         OP_ORI:  begin w_dec.cls = CL_IMM_Z; w_dec.alu_oprn = ALU_OR;  end
         OP_LUI:  w_dec.cls = CL_LUI;
         OP_BEQ:  begin w_dec.cls = CL_BEQ;   w_dec.alu_oprn = ALU_SUB; end
         OP_BNE:  begin w_dec.cls = CL_BNE;   w_dec.alu_oprn = ALU_SUB; end
         OP_LW:   begin w_dec.cls = CL_LW;    w_dec.alu_oprn = ALU_ADD; end
         OP_SW:   begin w_dec.cls = CL_SW;    w_dec.alu_oprn = ALU_ADD; end
         OP_JMP:  w_dec.cls = CL_JMP;
         OP_JAL:  w_dec.cls = CL_JAL;
         OP_PUSH: begin w_dec.cls = CL_PUSH;  w_dec.alu_oprn = ALU_SUB; end
         OP_POP:  begin w_dec.cls = CL_POP;   w_dec.alu_oprn = ALU_ADD; end
         default: w_dec.illegal = 1'b1;
      endcase
   end

   assign o_dec = w_dec;

endmodule

`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// cpu_control_unit: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer.
// Rev 1.0

module cpu_control_unit
   import cpu_control_unit_pkg::*;
#(
   parameter int CTRL_WIDTH  = 32,
   parameter int MEM_TIMEOUT = 15
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           i_instruction,
   input  logic                  i_zero,
   input  logic                  i_mem_ready,
   output logic [CTRL_WIDTH-1:0] o_ctrl,
   output logic                  o_mem_read,
   output logic                  o_mem_write,
   output logic                  o_halt,
   output logic                  o_illegal
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   logic [2:0]        r_state;
   logic              r_taken;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic              r_halt;
   logic              r_illegal;

   logic [2:0]        w_state_nxt;
   logic              w_fault;
   logic              w_stall;
   logic              w_timeout;
   logic              w_branch_taken;
   logic [WAIT_W-1:0] w_wait_inc;
   logic [31:0]       w_ctrl;
   logic [31:0]       w_alu_ctrl;
   logic              w_mem_read;
   logic              w_mem_write;
   decode_t           w_dec;
   logic              w_unused;

   cpu_control_unit_instr_decoder u_dec (
      .i_opcode (i_instruction[31:26]),
      .i_funct  (i_instruction[5:0]),
      .o_dec    (w_dec)
   );

   assign w_unused       = ^i_instruction[25:6];
   assign w_wait_inc     = r_wait_cnt + 1'b1;
   assign w_timeout      = (w_wait_inc == WAIT_W'(MEM_TIMEOUT));
   assign w_branch_taken = ((w_dec.cls == CL_BEQ) &&  i_zero) ||
                           ((w_dec.cls == CL_BNE) && !i_zero);

   always_comb begin
      w_state_nxt = r_state;
      w_fault     = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         S_IDLE:      w_state_nxt = S_FETCH;
         S_FETCH, S_MEMORY: begin
            if (i_mem_ready) begin
               w_state_nxt = (r_state == S_FETCH) ? S_DECODE : S_WRITEBACK;
            end else begin
               w_stall = 1'b1;
               if (w_timeout) begin
                  w_fault     = 1'b1;
                  w_state_nxt = S_HLT;
               end
            end
         end
         S_DECODE: begin
            if (w_dec.illegal) begin
               w_fault     = 1'b1;
               w_state_nxt = S_HLT;
            end else begin
               w_state_nxt = S_EXECUTE;
            end
         end
         S_EXECUTE:   w_state_nxt = is_mem_class(w_dec.cls) ? S_MEMORY : S_WRITEBACK;
         S_WRITEBACK: w_state_nxt = S_FETCH;
         S_HLT:       w_state_nxt = S_HLT;
         default: begin
            w_fault     = 1'b1;
            w_state_nxt = S_HLT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_taken    <= 1'b0;
         r_wait_cnt <= '0;
         r_halt     <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt != r_state) begin
            r_wait_cnt <= '0;
         end else if (w_stall) begin
            r_wait_cnt <= w_wait_inc;
         end
         if (r_state == S_EXECUTE) begin
            r_taken <= w_branch_taken;
         end
         if (w_fault) begin
            r_halt    <= 1'b1;
            r_illegal <= 1'b1;
         end
      end
   end

   // ALU operand/operation fields stay driven through MEMORY and WRITEBACK so
   // the combinational ALU result remains valid as address and write data.
   always_comb begin
      w_alu_ctrl                      = '0;
      w_alu_ctrl[C_ALU_MSB:C_ALU_LSB] = w_dec.alu_oprn;
      case (w_dec.cls)
         CL_SHIFT: begin
            w_alu_ctrl[C_OP2_SEL_4] = 1'b1;
            w_alu_ctrl[C_OP2_SEL_3] = 1'b1;
            w_alu_ctrl[C_OP2_SEL_1] = 1'b1;
         end
         CL_IMM_S, CL_LW, CL_SW: begin
            w_alu_ctrl[C_OP2_SEL_4] = 1'b1;
            w_alu_ctrl[C_OP2_SEL_2] = 1'b1;
         end
         CL_IMM_Z: w_alu_ctrl[C_OP2_SEL_4] = 1'b1;
         CL_PUSH, CL_POP: begin
            w_alu_ctrl[C_OP1_SEL]   = 1'b1;
            w_alu_ctrl[C_OP2_SEL_4] = 1'b1;
            w_alu_ctrl[C_OP2_SEL_3] = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_ctrl      = '0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_read           = 1'b1;
            w_ctrl[C_MA_SEL_2]   = 1'b1;
            w_ctrl[C_IR_LOAD]    = i_mem_ready;
         end
         S_DECODE: w_ctrl[C_REG_R] = 1'b1;
         S_EXECUTE: begin
            w_ctrl            = w_alu_ctrl;
            w_ctrl[C_REG_R]   = 1'b1;
            w_ctrl[C_SP_LOAD] = (w_dec.cls == CL_POP);
         end
         S_MEMORY: begin
            w_ctrl = w_alu_ctrl;
            case (w_dec.cls)
               CL_LW:   w_mem_read = 1'b1;
               CL_SW:   w_mem_write = 1'b1;
               CL_PUSH: begin
                  w_mem_write        = 1'b1;
                  w_ctrl[C_MA_SEL_1] = 1'b1;
                  w_ctrl[C_MD_SEL]   = 1'b1;
                  w_ctrl[C_R1_SEL]   = 1'b1;
               end
               CL_POP: begin
                  w_mem_read         = 1'b1;
                  w_ctrl[C_MA_SEL_1] = 1'b1;
               end
               default: ;
            endcase
         end
         S_WRITEBACK: begin
            w_ctrl             = w_alu_ctrl;
            w_ctrl[C_PC_LOAD]  = 1'b1;
            w_ctrl[C_PC_SEL_1] = (w_dec.cls != CL_JR);
            w_ctrl[C_PC_SEL_2] = r_taken;
            w_ctrl[C_PC_SEL_3] = (w_dec.cls != CL_JMP) && (w_dec.cls != CL_JAL);
            case (w_dec.cls)
               CL_RALU, CL_SHIFT: w_ctrl[C_REG_W] = 1'b1;
               CL_IMM_S, CL_IMM_Z: begin
                  w_ctrl[C_REG_W]    = 1'b1;
                  w_ctrl[C_WA_SEL_1] = 1'b1;
               end
               CL_LUI: begin
                  w_ctrl[C_REG_W]    = 1'b1;
                  w_ctrl[C_WA_SEL_1] = 1'b1;
                  w_ctrl[C_WD_SEL_2] = 1'b1;
               end
               CL_LW: begin
                  w_ctrl[C_REG_W]    = 1'b1;
                  w_ctrl[C_WA_SEL_1] = 1'b1;
                  w_ctrl[C_WD_SEL_1] = 1'b1;
               end
               CL_POP: begin
                  w_ctrl[C_REG_W]    = 1'b1;
                  w_ctrl[C_WA_SEL_3] = 1'b1;
                  w_ctrl[C_WD_SEL_1] = 1'b1;
               end
               CL_JAL: begin
                  w_ctrl[C_REG_W]    = 1'b1;
                  w_ctrl[C_WA_SEL_3] = 1'b1;
                  w_ctrl[C_WA_SEL_2] = 1'b1;
                  w_ctrl[C_WD_SEL_3] = 1'b1;
               end
               CL_PUSH: w_ctrl[C_SP_LOAD] = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign o_ctrl      = CTRL_WIDTH'(w_ctrl);
   assign o_mem_read  = w_mem_read;
   assign o_mem_write = w_mem_write;
   assign o_halt      = r_halt;
   assign o_illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// tb_cpu_control_unit: directed per-cycle vectors checked through an expectation queue.
// Rev 1.0

module tb_cpu_control_unit;

   localparam logic [31:0] PCL = 32'h1 << 0;
   localparam logic [31:0] PS1 = 32'h1 << 1;
   localparam logic [31:0] PS2 = 32'h1 << 2;
   localparam logic [31:0] PS3 = 32'h1 << 3;
   localparam logic [31:0] IRL = 32'h1 << 4;
   localparam logic [31:0] R1S = 32'h1 << 5;
   localparam logic [31:0] RR  = 32'h1 << 6;
   localparam logic [31:0] RW  = 32'h1 << 7;
   localparam logic [31:0] WA1 = 32'h1 << 8;
   localparam logic [31:0] WA2 = 32'h1 << 9;
   localparam logic [31:0] WA3 = 32'h1 << 10;
   localparam logic [31:0] WD1 = 32'h1 << 11;
   localparam logic [31:0] WD3 = 32'h1 << 13;
   localparam logic [31:0] SPL = 32'h1 << 14;
   localparam logic [31:0] OP1 = 32'h1 << 15;
   localparam logic [31:0] O21 = 32'h1 << 16;
   localparam logic [31:0] O22 = 32'h1 << 17;
   localparam logic [31:0] O23 = 32'h1 << 18;
   localparam logic [31:0] O24 = 32'h1 << 19;
   localparam logic [31:0] MA1 = 32'h1 << 26;
   localparam logic [31:0] MA2 = 32'h1 << 27;
   localparam logic [31:0] MDS = 32'h1 << 28;
   localparam logic [31:0] PCN = PCL | PS1 | PS3;

   localparam logic [31:0] I_ADD  = 32'h00221820;
   localparam logic [31:0] I_BEQ  = 32'h10220005;
   localparam logic [31:0] I_LW   = 32'h8C220004;
   localparam logic [31:0] I_PUSH = 32'h6C000000;
   localparam logic [31:0] I_POP  = 32'h70000000;
   localparam logic [31:0] I_JAL  = 32'h0C000010;
   localparam logic [31:0] I_BAD  = 32'hFC000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        zero = 1'b0;
   logic        ready = 1'b1;
   logic [31:0] o_ctrl;
   logic        o_mem_read, o_mem_write, o_halt, o_illegal;

   typedef struct {
      logic [31:0] ctrl;
      logic        rd, wr, halt, ill;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   cpu_control_unit #(.CTRL_WIDTH(32), .MEM_TIMEOUT(15)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_instruction (instr),
      .i_zero        (zero),
      .i_mem_ready   (ready),
      .o_ctrl        (o_ctrl),
      .o_mem_read    (o_mem_read),
      .o_mem_write   (o_mem_write),
      .o_halt        (o_halt),
      .o_illegal     (o_illegal)
   );

   function automatic logic [31:0] alu(input int n);
      return 32'(n) << 20;
   endfunction

   task automatic step(input logic rst, input logic [31:0] ins, input logic z, input logic rdy,
                       input logic [31:0] ec, input logic erd, input logic ewr,
                       input logic eh, input logic ei, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rst;
      instr = ins;
      zero  = z;
      ready = rdy;
      e.ctrl = ec; e.rd = erd; e.wr = ewr; e.halt = eh; e.ill = ei; e.name = nm;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if ({o_ctrl, o_mem_read, o_mem_write, o_halt, o_illegal} !==
                {e.ctrl, e.rd, e.wr, e.halt, e.ill}) begin
               n_bad++;
               $display("FAIL %s: got ctrl=%h rd=%b wr=%b halt=%b ill=%b, want ctrl=%h rd=%b wr=%b halt=%b ill=%b",
                        e.name, o_ctrl, o_mem_read, o_mem_write, o_halt, o_illegal,
                        e.ctrl, e.rd, e.wr, e.halt, e.ill);
            end
         end
      end
   end

   initial begin : driver
      // Reset held with memory ready, then release into IDLE
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, "rst_hold0");
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, "rst_hold1");
      step(1, 0, 0, 1, 0, 0, 0, 0, 0, "idle");

      step(1, I_ADD, 0, 1, MA2 | IRL,        1, 0, 0, 0, "add_fetch");
      step(1, I_ADD, 0, 1, RR,               0, 0, 0, 0, "add_decode");
      step(1, I_ADD, 0, 1, RR | alu(1),      0, 0, 0, 0, "add_execute");
      step(1, I_ADD, 0, 1, PCN | RW | alu(1), 0, 0, 0, 0, "add_writeback");

      // beq taken (ZERO=1 in EXECUTE), then ZERO changed to show it is latched
      step(1, I_BEQ, 0, 1, MA2 | IRL,        1, 0, 0, 0, "beq1_fetch");
      step(1, I_BEQ, 0, 1, RR,               0, 0, 0, 0, "beq1_decode");
      step(1, I_BEQ, 1, 1, RR | alu(2),      0, 0, 0, 0, "beq1_execute");
      step(1, I_BEQ, 0, 1, PCN | PS2 | alu(2), 0, 0, 0, 0, "beq1_wb_taken");
      step(1, I_BEQ, 0, 1, MA2 | IRL,        1, 0, 0, 0, "beq2_fetch");
      step(1, I_BEQ, 0, 1, RR,               0, 0, 0, 0, "beq2_decode");
      step(1, I_BEQ, 0, 1, RR | alu(2),      0, 0, 0, 0, "beq2_execute");
      step(1, I_BEQ, 1, 1, PCN | alu(2),     0, 0, 0, 0, "beq2_wb_not_taken");

      // lw with three stalled MEMORY cycles
      step(1, I_LW, 0, 1, MA2 | IRL,               1, 0, 0, 0, "lw_fetch");
      step(1, I_LW, 0, 1, RR,                      0, 0, 0, 0, "lw_decode");
      step(1, I_LW, 0, 1, RR | alu(1) | O24 | O22, 0, 0, 0, 0, "lw_execute");
      for (int i = 0; i < 3; i++)
         step(1, I_LW, 0, 0, alu(1) | O24 | O22,   1, 0, 0, 0, $sformatf("lw_mem_wait%0d", i));
      step(1, I_LW, 0, 1, alu(1) | O24 | O22,      1, 0, 0, 0, "lw_mem_done");
      step(1, I_LW, 0, 1, PCN | RW | WA1 | WD1 | alu(1) | O24 | O22, 0, 0, 0, 0, "lw_writeback");

      step(1, I_PUSH, 0, 1, MA2 | IRL,                           1, 0, 0, 0, "push_fetch");
      step(1, I_PUSH, 0, 1, RR,                                  0, 0, 0, 0, "push_decode");
      step(1, I_PUSH, 0, 1, RR | OP1 | O24 | O23 | alu(2),       0, 0, 0, 0, "push_execute");
      step(1, I_PUSH, 0, 1, R1S | MA1 | MDS | OP1 | O24 | O23 | alu(2), 0, 1, 0, 0, "push_memory");
      step(1, I_PUSH, 0, 1, PCN | SPL | OP1 | O24 | O23 | alu(2), 0, 0, 0, 0, "push_writeback");

      step(1, I_POP, 0, 1, MA2 | IRL,                            1, 0, 0, 0, "pop_fetch");
      step(1, I_POP, 0, 1, RR,                                   0, 0, 0, 0, "pop_decode");
      step(1, I_POP, 0, 1, RR | SPL | OP1 | O24 | O23 | alu(1),  0, 0, 0, 0, "pop_execute");
      step(1, I_POP, 0, 1, MA1 | OP1 | O24 | O23 | alu(1),       1, 0, 0, 0, "pop_memory");
      step(1, I_POP, 0, 1, PCN | RW | WA3 | WD1 | OP1 | O24 | O23 | alu(1), 0, 0, 0, 0, "pop_writeback");

      step(1, I_JAL, 0, 1, MA2 | IRL,                            1, 0, 0, 0, "jal_fetch");
      step(1, I_JAL, 0, 1, RR,                                   0, 0, 0, 0, "jal_decode");
      step(1, I_JAL, 0, 1, RR,                                   0, 0, 0, 0, "jal_execute");
      step(1, I_JAL, 0, 1, PCL | PS1 | RW | WA3 | WA2 | WD3,     0, 0, 0, 0, "jal_writeback");

      step(1, I_BAD, 0, 1, MA2 | IRL, 1, 0, 0, 0, "bad_fetch");
      step(1, I_BAD, 0, 1, RR,        0, 0, 0, 0, "bad_decode");
      for (int i = 0; i < 3; i++)
         step(1, I_BAD, 0, 1, 0,      0, 0, 1, 1, $sformatf("bad_halted%0d", i));

      // Fetch timeout: fifteen stalled FETCH cycles, then halted
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, "rst_clears_flags");
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, "idle2");
      for (int i = 0; i < 15; i++)
         step(1, 0, 0, 0, MA2, 1, 0, 0, 0, $sformatf("fetch_stall%0d", i));
      step(1, 0, 0, 0, 0, 0, 0, 1, 1, "fetch_timeout");
      step(1, 0, 0, 1, 0, 0, 0, 1, 1, "timeout_sticky");

      // Reset in the middle of a stalled fetch drops MEM_READ at once
      step(0, 0, 0, 0, 0,   0, 0, 0, 0, "rst3");
      step(1, 0, 0, 0, 0,   0, 0, 0, 0, "idle3");
      step(1, 0, 0, 0, MA2, 1, 0, 0, 0, "fetch_stall_a");
      step(1, 0, 0, 0, MA2, 1, 0, 0, 0, "fetch_stall_b");
      step(0, 0, 0, 0, 0,   0, 0, 0, 0, "rst_mid_access");
      step(1, 0, 0, 1, 0,   0, 0, 0, 0, "idle4");
      step(1, 0, 0, 1, MA2 | IRL, 1, 0, 0, 0, "fetch_after_rst");

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
